// File: rtl/msg_arbiter.sv
// Ring-node message arbiter: one-entry outbound slot shared by forwarded ring traffic and round-robin local requesters.
// Optional build macro MSG_ARBITER_FAIRNESS_EN forces a local grant after FWD_LIMIT consecutive forward grants.
module msg_arbiter #(
    parameter int                   NUM_REQ   = 4,
    parameter int                   PROC_BITS = 4,
    parameter int                   DATA_SIZE = 32,
    parameter logic [PROC_BITS-1:0] PROC_ID   = '0,
    parameter int                   FWD_LIMIT = 4
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_addr_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    input  logic                           net_valid_in,
    input  logic [DATA_SIZE+PROC_BITS-1:0] net_msg_in,
    output logic                           net_ready_out,
    output logic                           out_valid_out,
    output logic [DATA_SIZE+PROC_BITS-1:0] out_msg_out,
    input  logic                           out_ready_in,
    output logic                           local_valid_out,
    output logic [DATA_SIZE-1:0]           local_data_out
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int MSG_W = DATA_SIZE + PROC_BITS;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

    slot_t                 r_slot, w_slot_nxt;
    logic [MSG_W-1:0]      r_out_msg;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic                  r_local_valid;
    logic [DATA_SIZE-1:0]  r_local_data;

    logic [PROC_BITS-1:0]  w_dest;
    logic [DATA_SIZE-1:0]  w_payload;
    logic                  w_is_local;
    logic                  w_slot_free;
    logic                  w_any_req;
    logic                  w_force_local;
    logic                  w_fwd_take;
    logic                  w_local_take;
    logic                  w_grant_found;
    logic                  w_grant_en;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [PTR_W-1:0]      w_next_ptr;
    logic [PTR_W-1:0]      w_scan_idx;
    int unsigned           w_scan;
    logic [DATA_SIZE-1:0]  w_grant_addr;
    logic                  w_load;
    logic [MSG_W-1:0]      w_load_msg;

    assign w_dest      = net_msg_in[PROC_BITS-1:0];
    assign w_payload   = net_msg_in[MSG_W-1:PROC_BITS];
    assign w_is_local  = (w_dest == PROC_ID);
    assign w_slot_free = (r_slot == SLOT_EMPTY) || out_ready_in;
    assign w_any_req   = |req_valid_in;

`ifdef MSG_ARBITER_FAIRNESS_EN
    localparam int CNT_W = $clog2(FWD_LIMIT + 1);
    logic [CNT_W-1:0] r_fwd_cnt;

    assign w_force_local = w_any_req && (32'(r_fwd_cnt) >= FWD_LIMIT);

    // Counts forward wins only while a local requester is starved; saturates at the limit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fwd_cnt <= '0;
        end else if (w_grant_en) begin
            r_fwd_cnt <= '0;
        end else if (w_fwd_take && w_any_req && (32'(r_fwd_cnt) < FWD_LIMIT)) begin
            r_fwd_cnt <= r_fwd_cnt + 1'b1;
        end
    end
`else
    logic w_unused_fwd_limit;
    assign w_unused_fwd_limit = (FWD_LIMIT != 0);
    assign w_force_local      = 1'b0;
`endif

    assign w_fwd_take    = !rst_in && net_valid_in && !w_is_local && w_slot_free && !w_force_local;
    assign w_local_take  = !rst_in && net_valid_in && w_is_local;
    assign net_ready_out = w_fwd_take || w_local_take;

    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_next_ptr    = r_rr_ptr;
        w_scan        = 0;
        w_scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan     = (32'(r_rr_ptr) + k) % NUM_REQ;
            w_scan_idx = PTR_W'(w_scan);
            if (!w_grant_found && req_valid_in[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx;
                w_next_ptr    = PTR_W'((w_scan + 1) % NUM_REQ);
            end
        end
    end

    assign w_grant_en    = !rst_in && w_slot_free && !w_fwd_take && w_grant_found;
    assign req_ready_out = w_grant_en ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_grant_addr  = req_addr_in[w_grant_idx*DATA_SIZE +: DATA_SIZE];
    assign w_load        = w_fwd_take || w_grant_en;
    assign w_load_msg    = w_fwd_take ? net_msg_in
                                      : {w_grant_addr, w_grant_addr[DATA_SIZE-1 -: PROC_BITS]};

    always_ff @(posedge clk_in) begin
        if (rst_in) r_slot <= SLOT_EMPTY;
        else        r_slot <= w_slot_nxt;
    end

    always_comb begin
        w_slot_nxt = r_slot;
        case (r_slot)
            SLOT_EMPTY: if (w_load) w_slot_nxt = SLOT_FULL;
            SLOT_FULL:  if (out_ready_in && !w_load) w_slot_nxt = SLOT_EMPTY;
            default:    w_slot_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_out_msg     <= '0;
            r_rr_ptr      <= '0;
            r_local_valid <= 1'b0;
            r_local_data  <= '0;
        end else begin
            if (w_load)       r_out_msg    <= w_load_msg;
            if (w_grant_en)   r_rr_ptr     <= w_next_ptr;
            r_local_valid <= w_local_take;
            if (w_local_take) r_local_data <= w_payload;
        end
    end

    assign out_valid_out   = (r_slot == SLOT_FULL);
    assign out_msg_out     = r_out_msg;
    assign local_valid_out = r_local_valid;
    assign local_data_out  = r_local_data;

endmodule

// File: tb/tb_msg_arbiter.sv
// Directed bench for msg_arbiter (default parameters); the fairness section follows MSG_ARBITER_FAIRNESS_EN.
module tb_msg_arbiter;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic [3:0]   req_valid_in;
    logic [127:0] req_addr_in;
    logic [3:0]   req_ready_out;
    logic         net_valid_in;
    logic [35:0]  net_msg_in;
    logic         net_ready_out;
    logic         out_valid_out;
    logic [35:0]  out_msg_out;
    logic         out_ready_in;
    logic         local_valid_out;
    logic [31:0]  local_data_out;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] addr [4];
    logic [35:0] exp_msg;
    logic [35:0] held_msg;

    always #5 clk_in = ~clk_in;

    msg_arbiter #(
        .NUM_REQ   (4),
        .PROC_BITS (4),
        .DATA_SIZE (32),
        .PROC_ID   (4'b0000),
        .FWD_LIMIT (4)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_valid_in    (req_valid_in),
        .req_addr_in     (req_addr_in),
        .req_ready_out   (req_ready_out),
        .net_valid_in    (net_valid_in),
        .net_msg_in      (net_msg_in),
        .net_ready_out   (net_ready_out),
        .out_valid_out   (out_valid_out),
        .out_msg_out     (out_msg_out),
        .out_ready_in    (out_ready_in),
        .local_valid_out (local_valid_out),
        .local_data_out  (local_data_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        addr[0] = 32'hA000_0000;
        addr[1] = 32'h1111_1111;
        addr[2] = 32'h5000_0002;
        addr[3] = 32'hF000_0003;
        req_addr_in = {addr[3], addr[2], addr[1], addr[0]};

        // Reset with traffic present: no handshakes may be offered.
        rst_in       = 1'b1;
        req_valid_in = 4'hF;
        net_valid_in = 1'b1;
        net_msg_in   = {32'hCAFE_0000, 4'h0};
        out_ready_in = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready_out), 64'h0);
        check("rst_net_ready", 64'(net_ready_out), 64'h0);
        step();
        check("rst_out_valid", 64'(out_valid_out), 64'h0);
        check("rst_local_valid", 64'(local_valid_out), 64'h0);
        check("rst_out_msg", 64'(out_msg_out), 64'h0);
        check("rst_local_data", 64'(local_data_out), 64'h0);

        // Local delivery.
        rst_in       = 1'b0;
        req_valid_in = 4'h0;
        net_valid_in = 1'b1;
        net_msg_in   = {32'hDEADBEEF, 4'h0};
        #1;
        check("loc_net_ready", 64'(net_ready_out), 64'h1);
        check("loc_req_ready", 64'(req_ready_out), 64'h0);
        step();
        check("loc_valid", 64'(local_valid_out), 64'h1);
        check("loc_data", 64'(local_data_out), 64'hDEADBEEF);
        check("loc_out_valid", 64'(out_valid_out), 64'h0);
        net_valid_in = 1'b0;
        step();
        check("loc_pulse_end", 64'(local_valid_out), 64'h0);
        check("loc_data_hold", 64'(local_data_out), 64'hDEADBEEF);

        // Round robin with all requesters active, sink always ready.
        req_valid_in = 4'hF;
        out_ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), 64'(req_ready_out), 64'(4'b0001 << (k % 4)));
            step();
            exp_msg = {addr[k % 4], addr[k % 4][31:28]};
            check($sformatf("rr_valid_%0d", k), 64'(out_valid_out), 64'h1);
            check($sformatf("rr_msg_%0d", k), 64'(out_msg_out), 64'(exp_msg));
        end

        // Local inbound and local grant in the same cycle (pointer now at 1, only req 0 active).
        req_valid_in = 4'b0001;
        net_valid_in = 1'b1;
        net_msg_in   = {32'h0BADF00D, 4'h0};
        #1;
        check("both_net_ready", 64'(net_ready_out), 64'h1);
        check("both_req_ready", 64'(req_ready_out), 64'h1);
        step();
        check("both_local_valid", 64'(local_valid_out), 64'h1);
        check("both_local_data", 64'(local_data_out), 64'h0BADF00D);
        exp_msg = {addr[0], 4'hA};
        check("both_out_msg", 64'(out_msg_out), 64'(exp_msg));

        // Backpressure: slot full, forward message and requests must wait.
        held_msg     = exp_msg;
        out_ready_in = 1'b0;
        req_valid_in = 4'hF;
        net_msg_in   = {32'h0000_1234, 4'h3};
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("bp_net_ready_%0d", k), 64'(net_ready_out), 64'h0);
            check($sformatf("bp_req_ready_%0d", k), 64'(req_ready_out), 64'h0);
            step();
            check($sformatf("bp_valid_%0d", k), 64'(out_valid_out), 64'h1);
            check($sformatf("bp_msg_%0d", k), 64'(out_msg_out), 64'(held_msg));
        end
        out_ready_in = 1'b1;
        #1;
        check("drain_net_ready", 64'(net_ready_out), 64'h1);
        check("drain_fwd_prio", 64'(req_ready_out), 64'h0);
        step();
        check("drain_valid", 64'(out_valid_out), 64'h1);
        check("drain_msg", 64'(out_msg_out), 64'({32'h0000_1234, 4'h3}));

        // Reset while holding a message; pointer returns to 0.
        net_valid_in = 1'b0;
        out_ready_in = 1'b0;
        rst_in       = 1'b1;
        step();
        check("mid_rst_valid", 64'(out_valid_out), 64'h0);
        check("mid_rst_msg", 64'(out_msg_out), 64'h0);
        rst_in       = 1'b0;
        out_ready_in = 1'b1;
        req_valid_in = 4'hF;
        #1;
        check("post_rst_grant", 64'(req_ready_out), 64'h1);
        step();
        check("post_rst_msg", 64'(out_msg_out), 64'({addr[0], 4'hA}));
        req_valid_in = 4'h0;
        step();
        check("idle_valid", 64'(out_valid_out), 64'h0);
        check("idle_msg_hold", 64'(out_msg_out), 64'({addr[0], 4'hA}));

        // Continuous forward traffic versus a single local requester.
        req_valid_in = 4'b0001;
        net_valid_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            net_msg_in = {32'h0000_0100 + 32'(k), 4'h3};
            #1;
`ifdef MSG_ARBITER_FAIRNESS_EN
            if (k == 4) begin
                check($sformatf("fair_req_ready_%0d", k), 64'(req_ready_out), 64'h1);
                check($sformatf("fair_net_ready_%0d", k), 64'(net_ready_out), 64'h0);
                exp_msg = {addr[0], 4'hA};
            end else begin
                check($sformatf("fair_req_ready_%0d", k), 64'(req_ready_out), 64'h0);
                check($sformatf("fair_net_ready_%0d", k), 64'(net_ready_out), 64'h1);
                exp_msg = {32'h0000_0100 + 32'(k), 4'h3};
            end
`else
            check($sformatf("strict_req_ready_%0d", k), 64'(req_ready_out), 64'h0);
            check($sformatf("strict_net_ready_%0d", k), 64'(net_ready_out), 64'h1);
            exp_msg = {32'h0000_0100 + 32'(k), 4'h3};
`endif
            step();
            check($sformatf("fwd_msg_%0d", k), 64'(out_msg_out), 64'(exp_msg));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/msg_arbiter.md
MSG_ARBITER -- requirements
Module: msg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of local requesters (2..8).
REQ-002 SHALL have parameter PROC_BITS, default 4, processor-ID field width.
REQ-003 SHALL have parameter DATA_SIZE, default 32, payload/address width.
REQ-004 SHALL have parameter PROC_ID, default 4'b0000, ID of this node.
REQ-005 SHALL have parameter FWD_LIMIT, default 4, consecutive forward grants before a forced local grant (fairness build only).
REQ-006 SHALL have port clk_in  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port req_valid_in  input  NUM_REQ  per-requester request valid.
REQ-009 SHALL have port req_addr_in  input  NUM_REQ*DATA_SIZE  per-requester address; requester i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-010 SHALL have port req_ready_out  output  NUM_REQ  one-hot grant; transfer when valid and ready both high.
REQ-011 SHALL have port net_valid_in  input  1  inbound ring message valid.
REQ-012 SHALL have port net_msg_in  input  DATA_SIZE+PROC_BITS  inbound message {payload, dest_id}; dest_id in low PROC_BITS.
REQ-013 SHALL have port net_ready_out  output  1  inbound message accepted.
REQ-014 SHALL have port out_valid_out  output  1  outbound ring message valid.
REQ-015 SHALL have port out_msg_out  output  DATA_SIZE+PROC_BITS  outbound message {payload, dest_id}.
REQ-016 SHALL have port out_ready_in  input  1  downstream ring accepts outbound message.
REQ-017 SHALL have port local_valid_out  output  1  one-cycle pulse, message delivered to this node.
REQ-018 SHALL have port local_data_out  output  DATA_SIZE  delivered payload.

Function
REQ-019 Inbound message is "local" when dest_id == PROC_ID, otherwise "forward".
REQ-020 Local inbound SHALL always be accepted (net_ready_out=1); next cycle local_valid_out=1 and local_data_out=payload; no outbound slot used.
REQ-021 Output slot SHALL be a one-entry register with states EMPTY and FULL; slot_free = EMPTY or (FULL and out_ready_in).
REQ-022 Forward inbound SHALL be accepted (net_ready_out=1) only when slot_free; net_ready_out SHALL be combinational from net_valid_in, dest_id and slot_free.
REQ-023 When slot_free and a forward message is valid, it SHALL win the slot (ring traffic priority); no req_ready_out asserted that cycle.
REQ-024 When slot_free and no forward message, SHALL grant exactly one local requester by round-robin starting at pointer rr_ptr; req_ready_out combinational.
REQ-025 Local grant i SHALL load out_msg_out = {addr_i, addr_i[DATA_SIZE-1 -: PROC_BITS]} (owner derived from address top bits); rr_ptr <= (i+1) mod NUM_REQ.
REQ-026 Slot transitions: EMPTY->FULL on load; FULL->EMPTY on out_ready_in with no load; FULL->FULL on simultaneous drain and load (new message next cycle, zero bubble).
REQ-027 out_msg_out SHALL stay stable while out_valid_out=1 and out_ready_in=0.
REQ-028 Throughput SHALL be one outbound message per cycle when out_ready_in held high; latency input-accept to out_valid_out = 1 cycle.
REQ-029 Simultaneous local inbound and local grant SHALL both proceed in the same cycle.
REQ-030 No requests and no inbound: outputs hold, rr_ptr unchanged.

Reset
REQ-031 rst_in high at a clock edge SHALL set slot EMPTY, out_valid_out=0, local_valid_out=0, rr_ptr=0, fairness counter=0; out_msg_out and local_data_out SHALL be 0.
REQ-032 Reset mid-transfer SHALL discard the held message; req_ready_out and net_ready_out SHALL be 0 while rst_in is high.

Configuration
REQ-033 Macro MSG_ARBITER_FAIRNESS_EN: when defined, a counter SHALL count consecutive forward grants made while any req_valid_in is high; on reaching FWD_LIMIT the next slot_free cycle SHALL grant a local requester (forward stalled, net_ready_out=0), counter cleared on any local grant.
REQ-034 When MSG_ARBITER_FAIRNESS_EN is undefined, forward traffic SHALL have strict priority and no counter logic SHALL exist.

Verification
REQ-035 Reset, then net_msg_in={32'hDEADBEEF,4'h0}, valid 1 cycle -> net_ready_out=1, next cycle local_valid_out=1, local_data_out=32'hDEADBEEF, out_valid_out=0.
REQ-036 req_valid_in=4'b1111 held, out_ready_in=1 -> grants 0,1,2,3,0 on consecutive cycles; out_msg_out dest = addr top 4 bits each.
REQ-037 out_ready_in=0 with slot FULL, forward msg {32'h1234,4'h3} valid -> net_ready_out=0 and out_msg_out stable until out_ready_in=1; then forward loaded with no bubble.
REQ-038 Forward msgs valid every cycle plus req_valid_in=4'b0001, out_ready_in=1 -> without macro req 0 never granted; with macro and FWD_LIMIT=4 req 0 granted on 5th cycle.
REQ-039 rst_in asserted while out_valid_out=1 -> next cycle out_valid_out=0, rr_ptr=0; first post-reset grant goes to requester 0.
